// File: rtl/spi2usb_apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi2usb_apb_pkg
//  Description : Shared definitions for the spi2usb APB initiator. Holds the
//                default bus widths, the initiator FSM state encoding and the
//                addresses of the spi_slave register bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi2usb_apb_pkg;

    // Default APB address/data widths.
    localparam int C_AW_DEFAULT = 12;
    localparam int C_DW_DEFAULT = 8;

    // APB initiator state encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10,
        ST_RESP   = 2'b11
    } apb_state_e;

    // spi_slave register bank map.
    localparam logic [11:0] C_ADDR_STATUS0        = 12'h000;
    localparam logic [11:0] C_ADDR_STATUS1        = 12'h001;
    localparam logic [11:0] C_ADDR_STATUS2        = 12'h002;
    localparam logic [11:0] C_ADDR_STATUS3        = 12'h003;
    localparam logic [11:0] C_ADDR_VENDOR_CMD0    = 12'h004;
    localparam logic [11:0] C_ADDR_WDATA_ADDR_HS  = 12'h011;
    localparam logic [11:0] C_ADDR_WDATA_ADDR_H   = 12'h012;
    localparam logic [11:0] C_ADDR_WDATA_ADDR_L   = 12'h013;
    localparam logic [11:0] C_ADDR_RDATA_ADDR_HS  = 12'h014;
    localparam logic [11:0] C_ADDR_RDATA_ADDR_H   = 12'h015;
    localparam logic [11:0] C_ADDR_RDATA_ADDR_L   = 12'h016;

endpackage
`default_nettype wire

// File: rtl/spi_apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_apb_master
//  Description : APB initiator for the spi2usb controller. Accepts single
//                read/write requests from the SPI command decoder, runs each
//                one as an APB transfer into the spi_slave register bank and
//                returns read data plus error/timeout status. One transfer is
//                in flight at a time; every output is registered.
//  Ports       : cpu_clk, presetn (async, active-low)
//                req_*  : request handshake from the command decoder
//                rsp_*  : one-cycle response pulse with held status/data
//                p*     : APB initiator signals, pready_ack drives the bank's
//                         pready handshake input (high only in ACCESS)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_apb_master
    import spi2usb_apb_pkg::*;
#(
    parameter int          AW        = C_AW_DEFAULT,
    parameter int          DW        = C_DW_DEFAULT,
    parameter int unsigned TIMEOUT   = 255,      // 1..255, 8-bit counter
    parameter logic [2:0]  PPROT_VAL = 3'b000
) (
    input  logic          cpu_clk,
    input  logic          presetn,
    // request side
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    // response side
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_timeout,
    // APB initiator
    output logic [AW-1:0] paddr,
    output logic          pwrite,
    output logic          psel,
    output logic          penable,
    output logic [2:0]    pprot,
    output logic          pstrb,
    output logic [DW-1:0] pwdata,
    output logic          pready_ack,
    input  logic [DW-1:0] prdata,
    input  logic          pready,
    input  logic          pslverr
);

    // Counter value in the last ACCESS cycle before abort: with TIMEOUT=N the
    // transfer gets exactly N ACCESS cycles.
    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

    apb_state_e r_state;
    apb_state_e w_state_nxt;
    logic [7:0] r_tcnt;
    logic       w_accept;
    logic       w_done;
    logic       w_abort;

    assign pprot = PPROT_VAL;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk or negedge presetn) begin
        if (!presetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. pready is only looked at in ACCESS, so the bank's
    // reset-high pready cannot complete a transfer early. pready takes
    // priority over the timeout in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (r_tcnt == C_TMO_LAST) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs. Control outputs are decoded from the next state
    // so they line up with the state they belong to.
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk or negedge presetn) begin
        if (!presetn) begin
            req_ready   <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pready_ack  <= 1'b0;
            rsp_valid   <= 1'b0;
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            pstrb       <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            r_tcnt      <= '0;
        end else begin
            req_ready  <= (w_state_nxt == ST_IDLE);
            psel       <= (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS);
            penable    <= (w_state_nxt == ST_ACCESS);
            pready_ack <= (w_state_nxt == ST_ACCESS);
            rsp_valid  <= (w_state_nxt == ST_RESP);

            // Request latch: held stable until the next accepted request.
            if (w_accept) begin
                paddr  <= req_addr;
                pwrite <= req_write;
                pwdata <= req_wdata;
                pstrb  <= req_write;
            end

            // Response status is updated only when a transfer completes and
            // holds until the next one.
            if (w_done) begin
                rsp_rdata   <= pwrite ? '0 : prdata;
                rsp_err     <= pslverr;
                rsp_timeout <= 1'b0;
            end else if (w_abort) begin
                rsp_rdata   <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end

            // Counts ACCESS cycles without pready; zero on ACCESS entry.
            if (r_state == ST_ACCESS) begin
                r_tcnt <= r_tcnt + 8'd1;
            end else begin
                r_tcnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire
